// File: rtl/round_ctrl.sv
// Round sequencer for a reaction game: arms the downstream timer, tracks
// level/score/lives, handles pause, and keeps the best final score since reset.
module round_ctrl #(
    parameter int LIVES_INIT = 3,
    parameter int SCORE_MAX  = 99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_game,
    input  logic       pause_btn,
    input  logic       hit,
    input  logic       t_done,
    input  logic       t_flicker,
    output logic       t_start,
    output logic [4:0] t_length,
    output logic       t_freeze,
    output logic [2:0] level,
    output logic [6:0] score,
    output logic [6:0] best,
    output logic [1:0] lives,
    output logic       warn,
    output logic       game_over
);

    typedef enum logic [1:0] {IDLE, ARM, RUN, OVER} state_t;

    state_t     state, state_n;
    logic       paused, paused_n;
    logic       t_start_n;
    logic [4:0] t_length_n;
    logic [2:0] level_n;
    logic [6:0] score_n, best_n;
    logic [1:0] lives_n;

    // Round length shrinks by two cycles per level: 20, 18, ... 6.
    function automatic logic [4:0] len_of(input logic [2:0] l);
        return 5'd20 - {1'b0, l, 1'b0};
    endfunction

    function automatic logic [6:0] sat_score(input logic [6:0] s);
        return (s >= 7'(SCORE_MAX)) ? 7'(SCORE_MAX) : s + 7'd1;
    endfunction

    function automatic logic [2:0] sat_level(input logic [2:0] l);
        return (l == 3'd7) ? 3'd7 : l + 3'd1;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            paused   <= 1'b0;
            t_start  <= 1'b0;
            t_length <= 5'd20;
            level    <= 3'd0;
            score    <= 7'd0;
            best     <= 7'd0;
            lives    <= 2'd0;
        end else begin
            state    <= state_n;
            paused   <= paused_n;
            t_start  <= t_start_n;
            t_length <= t_length_n;
            level    <= level_n;
            score    <= score_n;
            best     <= best_n;
            lives    <= lives_n;
        end
    end

    always_comb begin
        state_n    = state;
        paused_n   = paused;
        t_start_n  = 1'b0;
        t_length_n = t_length;
        level_n    = level;
        score_n    = score;
        best_n     = best;
        lives_n    = lives;
        case (state)
            IDLE, OVER: begin
                if (start_game) begin
                    state_n    = ARM;
                    level_n    = 3'd0;
                    score_n    = 7'd0;
                    lives_n    = 2'(LIVES_INIT);
                    paused_n   = 1'b0;
                    t_start_n  = 1'b1;
                    t_length_n = len_of(3'd0);
                end
            end
            ARM: state_n = RUN;
            RUN: begin
                // A pause press consumes the cycle, so a simultaneous hit is dropped.
                if (pause_btn) begin
                    paused_n = ~paused;
                end else if (!paused) begin
                    if (hit) begin
                        state_n    = ARM;
                        score_n    = sat_score(score);
                        level_n    = sat_level(level);
                        t_start_n  = 1'b1;
                        t_length_n = len_of(sat_level(level));
                    end else if (t_done) begin
                        lives_n = lives - 2'd1;
                        if (lives == 2'd1) begin
                            state_n = OVER;
                            if (score > best) best_n = score;
                        end else begin
                            state_n    = ARM;
                            t_start_n  = 1'b1;
                            t_length_n = len_of(level);
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign t_freeze  = paused;
    assign warn      = t_flicker && (state == RUN) && !paused;
    assign game_over = (state == OVER);

endmodule

// File: tb/tb_round_ctrl.sv
// Directed vector bench for round_ctrl: each vector drives one cycle of inputs
// and lists the outputs expected just after the following rising edge.
module tb_round_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_game, pause_btn, hit, t_done, t_flicker;
    logic       t_start, t_freeze, warn, game_over;
    logic [4:0] t_length;
    logic [2:0] level;
    logic [6:0] score, best;
    logic [1:0] lives;

    int n_vec = 0;
    int n_bad = 0;

    round_ctrl dut (
        .clk(clk), .reset(reset), .start_game(start_game), .pause_btn(pause_btn),
        .hit(hit), .t_done(t_done), .t_flicker(t_flicker), .t_start(t_start),
        .t_length(t_length), .t_freeze(t_freeze), .level(level), .score(score),
        .best(best), .lives(lives), .warn(warn), .game_over(game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       sg, pb, h, td, tf;
        logic       st;
        logic [4:0] len;
        logic       frz;
        logic [2:0] lvl;
        logic [6:0] sc, bst;
        logic [1:0] lv;
        logic       w, go;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input string name,
                                input logic sg, pb, h, td, tf,
                                input logic st, input int len, input logic frz,
                                input int lvl, sc, bst, lv,
                                input logic w, go);
        vec_t v;
        v.name = name; v.sg = sg; v.pb = pb; v.h = h; v.td = td; v.tf = tf;
        v.st = st; v.len = 5'(len); v.frz = frz; v.lvl = 3'(lvl);
        v.sc = 7'(sc); v.bst = 7'(bst); v.lv = 2'(lv); v.w = w; v.go = go;
        return v;
    endfunction

    task automatic check(input vec_t v);
        logic [27:0] act, exp;
        act = {t_start, t_length, t_freeze, level, score, best, lives, warn, game_over};
        exp = {v.st, v.len, v.frz, v.lvl, v.sc, v.bst, v.lv, v.w, v.go};
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got st=%b len=%0d frz=%b lvl=%0d sc=%0d best=%0d lives=%0d warn=%b go=%b, want st=%b len=%0d frz=%b lvl=%0d sc=%0d best=%0d lives=%0d warn=%b go=%b",
                     v.name, t_start, t_length, t_freeze, level, score, best, lives, warn, game_over,
                     v.st, v.len, v.frz, v.lvl, v.sc, v.bst, v.lv, v.w, v.go);
        end
    endtask

    task automatic apply(input vec_t v);
        start_game = v.sg; pause_btn = v.pb; hit = v.h; t_done = v.td; t_flicker = v.tf;
        @(posedge clk);
        #1;
        check(v);
    endtask

    task automatic idle_inputs();
        start_game = 0; pause_btn = 0; hit = 0; t_done = 0; t_flicker = 0;
    endtask

    initial begin
        //       name          sg pb h td tf   st len frz lvl sc bst lv w go
        tbl.push_back(mk("start",      1,0,0,0,0, 1,20,0,0,0,0,3,0,0));
        tbl.push_back(mk("run_warn",   0,0,0,0,1, 0,20,0,0,0,0,3,1,0));
        tbl.push_back(mk("start_ign",  1,0,0,0,0, 0,20,0,0,0,0,3,0,0));
        tbl.push_back(mk("hit1",       0,0,1,0,0, 1,18,0,1,1,0,3,0,0));
        tbl.push_back(mk("run1",       0,0,0,0,0, 0,18,0,1,1,0,3,0,0));
        tbl.push_back(mk("hit_tdone",  0,0,1,1,0, 1,16,0,2,2,0,3,0,0));
        tbl.push_back(mk("run2",       0,0,0,0,0, 0,16,0,2,2,0,3,0,0));
        tbl.push_back(mk("pause",      0,1,0,0,0, 0,16,1,2,2,0,3,0,0));
        tbl.push_back(mk("paused_ign", 0,0,1,1,1, 0,16,1,2,2,0,3,0,0));
        tbl.push_back(mk("unpause",    0,1,0,0,0, 0,16,0,2,2,0,3,0,0));
        tbl.push_back(mk("hit3",       0,0,1,0,0, 1,14,0,3,3,0,3,0,0));
        tbl.push_back(mk("run3",       0,0,0,0,0, 0,14,0,3,3,0,3,0,0));
        tbl.push_back(mk("pause_hit",  0,1,1,0,0, 0,14,1,3,3,0,3,0,0));
        tbl.push_back(mk("unpause2",   0,1,0,0,0, 0,14,0,3,3,0,3,0,0));
        tbl.push_back(mk("hit4",       0,0,1,0,0, 1,12,0,4,4,0,3,0,0));
        tbl.push_back(mk("run4",       0,0,0,0,0, 0,12,0,4,4,0,3,0,0));
        tbl.push_back(mk("hit5",       0,0,1,0,0, 1,10,0,5,5,0,3,0,0));
        tbl.push_back(mk("run5",       0,0,0,0,0, 0,10,0,5,5,0,3,0,0));
        tbl.push_back(mk("hit6",       0,0,1,0,0, 1, 8,0,6,6,0,3,0,0));
        tbl.push_back(mk("run6",       0,0,0,0,0, 0, 8,0,6,6,0,3,0,0));
        tbl.push_back(mk("hit7",       0,0,1,0,0, 1, 6,0,7,7,0,3,0,0));
        tbl.push_back(mk("run7",       0,0,0,0,0, 0, 6,0,7,7,0,3,0,0));
        tbl.push_back(mk("hit8_sat",   0,0,1,0,0, 1, 6,0,7,8,0,3,0,0));
        tbl.push_back(mk("run8",       0,0,0,0,0, 0, 6,0,7,8,0,3,0,0));
        tbl.push_back(mk("miss1",      0,0,0,1,0, 1, 6,0,7,8,0,2,0,0));
        tbl.push_back(mk("run9",       0,0,0,0,0, 0, 6,0,7,8,0,2,0,0));
        tbl.push_back(mk("miss2",      0,0,0,1,0, 1, 6,0,7,8,0,1,0,0));
        tbl.push_back(mk("run10",      0,0,0,0,0, 0, 6,0,7,8,0,1,0,0));
        tbl.push_back(mk("miss3_over", 0,0,0,1,0, 0, 6,0,7,8,8,0,0,1));
        tbl.push_back(mk("over_ign",   0,1,1,0,1, 0, 6,0,7,8,8,0,0,1));
        tbl.push_back(mk("restart",    1,0,0,0,0, 1,20,0,0,0,8,3,0,0));
        tbl.push_back(mk("run_new",    0,0,0,0,0, 0,20,0,0,0,8,3,0,0));

        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check(mk("reset_state", 0,0,0,0,0, 0,20,0,0,0,0,0,0,0));
        @(negedge clk);
        reset = 1'b0;

        foreach (tbl[i]) apply(tbl[i]);

        // Mid-game reset: build score 5, pause, then reset asynchronously.
        for (int i = 1; i <= 5; i++) begin
            apply(mk("pre_hit", 0,0,1,0,0, 1,20-2*i,0,i,i,8,3,0,0));
            apply(mk("pre_run", 0,0,0,0,0, 0,20-2*i,0,i,i,8,3,0,0));
        end
        apply(mk("pre_pause", 0,1,0,0,0, 0,10,1,5,5,8,3,0,0));
        idle_inputs();
        #1 reset = 1'b1;
        #1 check(mk("async_reset", 0,0,0,0,0, 0,20,0,0,0,0,0,0,0));
        @(negedge clk);
        reset = 1'b0;
        apply(mk("start_after_rst", 1,0,0,0,0, 1,20,0,0,0,0,3,0,0));
        apply(mk("r_run",  0,0,0,0,0, 0,20,0,0,0,0,3,0,0));
        apply(mk("r_hit",  0,0,1,0,0, 1,18,0,1,1,0,3,0,0));
        apply(mk("r_run1", 0,0,0,0,0, 0,18,0,1,1,0,3,0,0));
        apply(mk("r_miss1",0,0,0,1,0, 1,18,0,1,1,0,2,0,0));
        apply(mk("r_run2", 0,0,0,0,1, 0,18,0,1,1,0,2,1,0));
        apply(mk("r_miss2",0,0,0,1,0, 1,18,0,1,1,0,1,0,0));
        apply(mk("r_run3", 0,0,0,0,0, 0,18,0,1,1,0,1,0,0));
        apply(mk("r_over", 0,0,0,1,0, 0,18,0,1,1,1,0,0,1));
        apply(mk("r_restart",1,0,0,0,0, 1,20,0,0,0,1,3,0,0));
        idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
